// File: rtl/aes_key_expander.sv
// -----------------------------------------------------------------------------
// aes_key_expander
//   Iterative AES key schedule generator (FIPS-197). A legal start captures the
//   left-aligned key, then one 32-bit schedule word is produced per clock until
//   w[4*Nr+3] is written. The finished schedule is held in a word buffer and
//   read back one 128-bit round key at a time through a combinational port.
//
// Parameters
//   MAX_KEY_BITS : largest accepted key length (128, 192 or 256).
//
// Optional feature
//   KEYEXP_ZEROIZE_EN : when defined, adds input zeroize that wipes the stored
//                       schedule and aborts any expansion in progress.
//
// Ports
//   clk      in   1    clock, rising edge
//   rst_n    in   1    asynchronous active-low reset
//   zeroize  in   1    synchronous wipe (only with KEYEXP_ZEROIZE_EN)
//   start    in   1    expansion request, sampled while ready=1
//   key_len  in   2    00=128, 01=192, 10=256, 11=illegal
//   key      in   256  left-aligned key, key[0] is the MSB
//   ready    out  1    block is idle
//   done     out  1    one-cycle pulse, schedule complete
//   cfg_err  out  1    one-cycle pulse, start rejected
//   rk_nr    out  4    round count of the stored schedule
//   rk_addr  in   4    round-key index to read
//   rk_data  out  128  round key rk_addr, zero when invalid or out of range
//   rk_valid out  1    stored schedule is complete
// -----------------------------------------------------------------------------
module aes_key_expander #(
   parameter int MAX_KEY_BITS = 256
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef KEYEXP_ZEROIZE_EN
   input  logic         zeroize,
`endif
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [0:255] key,
   output logic         ready,
   output logic         done,
   output logic         cfg_err,
   output logic [3:0]   rk_nr,
   input  logic [3:0]   rk_addr,
   output logic [0:127] rk_data,
   output logic         rk_valid
);

   localparam int BUF_WORDS = 4*((MAX_KEY_BITS/32)+7);
   localparam int IW        = $clog2(BUF_WORDS);

   // FIPS-197 forward S-box, byte 00 in the most significant position.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {S_IDLE, S_EXPAND} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_w [BUF_WORDS];
   logic [IW-1:0] r_i;
   logic [2:0]    r_mod;     // i mod Nk, wraps instead of dividing
   logic [3:0]    r_nk;
   logic [7:0]    r_rcon;
   logic [3:0]    r_nr;
   logic          r_valid, r_done, r_cfg_err;

   logic          w_zeroize, w_len_ok, w_start_ok, w_start_bad, w_last_hit;
   logic [3:0]    w_req_nk, w_req_nr;
   logic [IW-1:0] w_last;
   logic [31:0]   w_prev, w_old, w_temp, w_new;
   logic          w_rd_ok;
   logic [IW-1:0] w_base;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      // byte b sits at bits 8*(255-b)+7 downto 8*(255-b)
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

`ifdef KEYEXP_ZEROIZE_EN
   assign w_zeroize = zeroize;
`else
   assign w_zeroize = 1'b0;
`endif

   always_comb begin
      w_req_nk = 4'd4;
      w_req_nr = 4'd10;
      w_len_ok = 1'b1;
      case (key_len)
         2'b00: w_len_ok = 1'b1;
         2'b01: begin
            w_req_nk = 4'd6;
            w_req_nr = 4'd12;
            w_len_ok = (MAX_KEY_BITS >= 192);
         end
         2'b10: begin
            w_req_nk = 4'd8;
            w_req_nr = 4'd14;
            w_len_ok = (MAX_KEY_BITS >= 256);
         end
         default: w_len_ok = 1'b0;
      endcase
   end

   // zeroize wins over a simultaneous start, including a rejected one
   assign w_start_ok  = (r_state == S_IDLE) && start && w_len_ok  && !w_zeroize;
   assign w_start_bad = (r_state == S_IDLE) && start && !w_len_ok && !w_zeroize;

   // last word index is 4*Nr+3
   assign w_last     = IW'({r_nr, 2'b11});
   assign w_last_hit = (r_i == w_last);

   always_comb begin
      w_prev = r_w[r_i - IW'(1)];
      w_old  = r_w[r_i - IW'(r_nk)];
      if (r_mod == 3'd0)
         w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
      else if (r_nk == 4'd8 && r_mod == 3'd4)
         w_temp = sub_word(w_prev);
      else
         w_temp = w_prev;
      w_new = w_old ^ w_temp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start_ok) w_state_nxt = S_EXPAND;
         S_EXPAND: if (w_zeroize || w_last_hit) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < BUF_WORDS; k++) r_w[k] <= '0;
         r_i       <= '0;
         r_mod     <= '0;
         r_nk      <= 4'd4;
         r_rcon    <= 8'h01;
         r_nr      <= '0;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         if (w_zeroize) begin
            for (int k = 0; k < BUF_WORDS; k++) r_w[k] <= '0;
            r_valid <= 1'b0;
            r_nr    <= '0;
         end else if (w_start_ok) begin
            for (int k = 0; k < 8; k++)
               if (4'(k) < w_req_nk) r_w[k] <= key[32*k +: 32];
            r_i     <= IW'(w_req_nk);
            r_mod   <= '0;
            r_nk    <= w_req_nk;
            r_rcon  <= 8'h01;
            r_nr    <= w_req_nr;
            r_valid <= 1'b0;
         end else if (w_start_bad) begin
            r_cfg_err <= 1'b1;
         end else if (r_state == S_EXPAND) begin
            r_w[r_i] <= w_new;
            r_i      <= r_i + IW'(1);
            if (r_mod == 3'd0) r_rcon <= xtime(r_rcon);
            r_mod <= ({1'b0, r_mod} == (r_nk - 4'd1)) ? 3'd0 : r_mod + 3'd1;
            if (w_last_hit) begin
               r_valid <= 1'b1;
               r_done  <= 1'b1;
            end
         end
      end
   end

   // read port: index forced to 0 when the read is not allowed so it never
   // reaches past the end of the buffer
   assign w_rd_ok = r_valid && (rk_addr <= r_nr);
   assign w_base  = w_rd_ok ? IW'({rk_addr, 2'b00}) : '0;
   assign rk_data = w_rd_ok ? {r_w[w_base], r_w[w_base + IW'(1)],
                               r_w[w_base + IW'(2)], r_w[w_base + IW'(3)]} : '0;

   assign ready    = (r_state == S_IDLE);
   assign done     = r_done;
   assign cfg_err  = r_cfg_err;
   assign rk_nr    = r_nr;
   assign rk_valid = r_valid;

endmodule

// File: tb/tb_aes_key_expander.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expander
//   Self-checking bench for aes_key_expander. A second instance built with
//   MAX_KEY_BITS=128 covers the over-length rejection. Expected schedules come
//   from FIPS-197 vectors and from a reference model whose S-box is derived
//   from the GF(2^8) inverse plus affine transform.
// -----------------------------------------------------------------------------
module tb_aes_key_expander;

   localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   logic         clk, rst_n, start, start128;
   logic [1:0]   key_len;
   logic [0:255] key;
   logic [3:0]   rk_addr;
   logic         ready, done, cfg_err, rk_valid;
   logic [3:0]   rk_nr;
   logic [0:127] rk_data;
   logic         ready128, done128, cfg_err128, rk_valid128;
   logic [3:0]   rk_nr128;
   logic [0:127] rk_data128;
`ifdef KEYEXP_ZEROIZE_EN
   logic         zeroize;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  sb [256];
   logic [31:0] mw [60];

   aes_key_expander #(.MAX_KEY_BITS(256)) u_dut (
      .clk(clk), .rst_n(rst_n),
`ifdef KEYEXP_ZEROIZE_EN
      .zeroize(zeroize),
`endif
      .start(start), .key_len(key_len), .key(key),
      .ready(ready), .done(done), .cfg_err(cfg_err), .rk_nr(rk_nr),
      .rk_addr(rk_addr), .rk_data(rk_data), .rk_valid(rk_valid)
   );

   aes_key_expander #(.MAX_KEY_BITS(128)) u_dut128 (
      .clk(clk), .rst_n(rst_n),
`ifdef KEYEXP_ZEROIZE_EN
      .zeroize(zeroize),
`endif
      .start(start128), .key_len(key_len), .key(key),
      .ready(ready128), .done(done128), .cfg_err(cfg_err128), .rk_nr(rk_nr128),
      .rk_addr(rk_addr), .rk_data(rk_data128), .rk_valid(rk_valid128)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int n = 0; n < 8; n++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         b = 8'(x);
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(b, 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   task automatic model_expand(input logic [0:255] k, input int nk);
      logic [7:0]  rc;
      logic [31:0] t;
      int nr;
      nr = nk + 6;
      for (int i = 0; i < nk; i++) mw[i] = k[32*i +: 32];
      rc = 8'h01;
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = mw[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         mw[i] = mw[i-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] model_rk(input int r);
      return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic do_start(input logic [1:0] len, input logic [0:255] k);
      key_len = len;
      key     = k;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int edges);
      edges = -1;
      for (int n = 1; n <= limit; n++) begin
         @(posedge clk); #1;
         if (done) begin
            edges = n;
            break;
         end
      end
   endtask

   function automatic logic [127:0] junk128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start128 = 1'b0; key_len = 2'b00; key = '0; rk_addr = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
      zeroize = 1'b0;
`endif
      @(posedge clk); @(posedge clk); #1;
      n_checks++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", ready); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
      n_checks++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err: got %b expected 0", cfg_err); else n_pass++;
      n_checks++; if (rk_valid !== 1'b0) $display("FAIL rst_rk_valid: got %b expected 0", rk_valid); else n_pass++;
      n_checks++; if (rk_nr !== 4'd0) $display("FAIL rst_rk_nr: got %0d expected 0", rk_nr); else n_pass++;
      n_checks++; if (rk_data !== 128'h0) $display("FAIL rst_rk_data: got %h expected 0", rk_data); else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_kat128();
      int edges;
      do_start(2'b00, {K128, junk128()});
      n_checks++; if (ready !== 1'b0 || rk_valid !== 1'b0) $display("FAIL kat128_busy: got ready=%b rk_valid=%b expected 0/0", ready, rk_valid); else n_pass++;
      wait_done(100, edges);
      n_checks++; if (edges !== 40) $display("FAIL kat128_latency: got %0d expected 40", edges); else n_pass++;
      n_checks++; if (rk_nr !== 4'd10 || rk_valid !== 1'b1 || ready !== 1'b1) $display("FAIL kat128_status: got nr=%0d valid=%b ready=%b expected 10/1/1", rk_nr, rk_valid, ready); else n_pass++;
      rk_addr = 4'd0; #1;
      n_checks++; if (rk_data !== K128) $display("FAIL kat128_rk0: got %h expected %h", rk_data, K128); else n_pass++;
      rk_addr = 4'd1; #1;
      n_checks++; if (rk_data !== R128_1) $display("FAIL kat128_rk1: got %h expected %h", rk_data, R128_1); else n_pass++;
      rk_addr = 4'd10; #1;
      n_checks++; if (rk_data !== R128_10) $display("FAIL kat128_rk10: got %h expected %h", rk_data, R128_10); else n_pass++;
      rk_addr = 4'd11; #1;
      n_checks++; if (rk_data !== 128'h0) $display("FAIL kat128_rk11_range: got %h expected 0", rk_data); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) $display("FAIL kat128_done_pulse: got %b expected 0", done); else n_pass++;
   endtask

   task automatic test_kat192();
      int edges;
      do_start(2'b01, {K192, 64'hdeadbeef_cafef00d});
      wait_done(100, edges);
      n_checks++; if (edges !== 46) $display("FAIL kat192_latency: got %0d expected 46", edges); else n_pass++;
      n_checks++; if (rk_nr !== 4'd12) $display("FAIL kat192_rk_nr: got %0d expected 12", rk_nr); else n_pass++;
      rk_addr = 4'd12; #1;
      n_checks++; if (rk_data !== R192_12) $display("FAIL kat192_rk12: got %h expected %h", rk_data, R192_12); else n_pass++;
      rk_addr = 4'd13; #1;
      n_checks++; if (rk_data !== 128'h0) $display("FAIL kat192_rk13_range: got %h expected 0", rk_data); else n_pass++;
   endtask

   task automatic test_kat256();
      int edges;
      do_start(2'b10, K256);
      wait_done(100, edges);
      n_checks++; if (edges !== 52) $display("FAIL kat256_latency: got %0d expected 52", edges); else n_pass++;
      n_checks++; if (rk_nr !== 4'd14) $display("FAIL kat256_rk_nr: got %0d expected 14", rk_nr); else n_pass++;
      rk_addr = 4'd14; #1;
      n_checks++; if (rk_data !== R256_14) $display("FAIL kat256_rk14: got %h expected %h", rk_data, R256_14); else n_pass++;
      rk_addr = 4'd15; #1;
      n_checks++; if (rk_data !== 128'h0) $display("FAIL kat256_rk15_range: got %h expected 0", rk_data); else n_pass++;
   endtask

   task automatic test_illegal();
      int edges;
      // key_len=11 on the 256-bit instance holding the 256-bit vector schedule
      rk_addr = 4'd14;
      do_start(2'b11, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      n_checks++; if (cfg_err !== 1'b1) $display("FAIL ill11_cfg_err: got %b expected 1", cfg_err); else n_pass++;
      n_checks++; if (ready !== 1'b1 || rk_valid !== 1'b1 || rk_nr !== 4'd14) $display("FAIL ill11_state: got ready=%b valid=%b nr=%0d expected 1/1/14", ready, rk_valid, rk_nr); else n_pass++;
      n_checks++; if (rk_data !== R256_14) $display("FAIL ill11_retain: got %h expected %h", rk_data, R256_14); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (cfg_err !== 1'b0 || done !== 1'b0) $display("FAIL ill11_pulse: got cfg_err=%b done=%b expected 0/0", cfg_err, done); else n_pass++;

      // over-length key on the 128-bit instance after a good 128-bit run
      key_len = 2'b00; key = {K128, junk128()}; start128 = 1'b1;
      @(posedge clk); #1;
      start128 = 1'b0;
      edges = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (done128) begin
            edges = n;
            break;
         end
      end
      n_checks++; if (edges !== 40) $display("FAIL max128_latency: got %0d expected 40", edges); else n_pass++;
      rk_addr = 4'd10;
      key_len = 2'b10; key = K256; start128 = 1'b1;
      @(posedge clk); #1;
      start128 = 1'b0;
      n_checks++; if (cfg_err128 !== 1'b1) $display("FAIL max128_cfg_err: got %b expected 1", cfg_err128); else n_pass++;
      n_checks++; if (ready128 !== 1'b1 || rk_valid128 !== 1'b1 || rk_nr128 !== 4'd10) $display("FAIL max128_state: got ready=%b valid=%b nr=%0d expected 1/1/10", ready128, rk_valid128, rk_nr128); else n_pass++;
      n_checks++; if (rk_data128 !== R128_10) $display("FAIL max128_retain: got %h expected %h", rk_data128, R128_10); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (cfg_err128 !== 1'b0 || ready128 !== 1'b1) $display("FAIL max128_pulse: got cfg_err=%b ready=%b expected 0/1", cfg_err128, ready128); else n_pass++;
   endtask

   task automatic test_random();
      int edges, len, nk, nr;
      logic [0:255] k;
      logic [127:0] exp;
      for (int it = 0; it < 6; it++) begin
         len = $urandom_range(0, 2);
         nk  = 4 + 2*len;
         nr  = nk + 6;
         k   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         model_expand(k, nk);
         do_start(2'(len), k);
         wait_done(100, edges);
         n_checks++; if (edges !== 4*(nr+1)-nk) $display("FAIL rand%0d_latency: got %0d expected %0d", it, edges, 4*(nr+1)-nk); else n_pass++;
         n_checks++; if (rk_nr !== 4'(nr)) $display("FAIL rand%0d_rk_nr: got %0d expected %0d", it, rk_nr, nr); else n_pass++;
         for (int r = 0; r < 16; r++) begin
            rk_addr = 4'(r); #1;
            exp = (r <= nr) ? model_rk(r) : 128'h0;
            n_checks++; if (rk_data !== exp) $display("FAIL rand%0d_rk%0d: got %h expected %h", it, r, rk_data, exp); else n_pass++;
         end
      end
   endtask

   task automatic test_busy_start();
      int edges, errs;
      key_len = 2'b00; key = {K128, junk128()}; start = 1'b1;
      @(posedge clk); #1;
      edges = -1; errs = 0;
      for (int n = 1; n <= 100; n++) begin
         if (n == 5) begin
            key_len = 2'b10;
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (cfg_err) errs++;
         if (done) begin
            edges = n;
            break;
         end
      end
      start = 1'b0;
      n_checks++; if (edges !== 40) $display("FAIL busy_latency: got %0d expected 40", edges); else n_pass++;
      n_checks++; if (errs !== 0) $display("FAIL busy_cfg_err: got %0d pulses expected 0", errs); else n_pass++;
      n_checks++; if (rk_nr !== 4'd10) $display("FAIL busy_rk_nr: got %0d expected 10", rk_nr); else n_pass++;
      rk_addr = 4'd1; #1;
      n_checks++; if (rk_data !== R128_1) $display("FAIL busy_rk1: got %h expected %h", rk_data, R128_1); else n_pass++;
      rk_addr = 4'd10; #1;
      n_checks++; if (rk_data !== R128_10) $display("FAIL busy_rk10: got %h expected %h", rk_data, R128_10); else n_pass++;
   endtask

   task automatic test_abort();
      int saw;
      do_start(2'b10, K256);
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (ready !== 1'b1 || rk_valid !== 1'b0 || rk_nr !== 4'd0) $display("FAIL abort_async: got ready=%b valid=%b nr=%0d expected 1/0/0", ready, rk_valid, rk_nr); else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw = 0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         if (done) saw++;
      end
      n_checks++; if (saw !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", saw); else n_pass++;
      rk_addr = 4'd14; #1;
      n_checks++; if (rk_valid !== 1'b0 || rk_data !== 128'h0) $display("FAIL abort_cleared: got valid=%b data=%h expected 0/0", rk_valid, rk_data); else n_pass++;
      test_kat128();
   endtask

`ifdef KEYEXP_ZEROIZE_EN
   task automatic test_zeroize();
      int saw;
      do_start(2'b10, K256);
      repeat (20) @(posedge clk);
      #1;
      zeroize = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      zeroize = 1'b0; start = 1'b0;
      n_checks++; if (ready !== 1'b1 || rk_valid !== 1'b0 || rk_nr !== 4'd0) $display("FAIL zero_state: got ready=%b valid=%b nr=%0d expected 1/0/0", ready, rk_valid, rk_nr); else n_pass++;
      saw = 0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         if (done) saw++;
      end
      n_checks++; if (saw !== 0) $display("FAIL zero_no_done: got %0d pulses expected 0", saw); else n_pass++;
      test_kat128();
   endtask
`endif

   initial begin
      build_sbox();
      test_reset();
      test_kat128();
      test_kat192();
      test_kat256();
      test_illegal();
      test_random();
      test_busy_start();
      test_abort();
`ifdef KEYEXP_ZEROIZE_EN
      test_zeroize();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
